// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pool engine.
package pool_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 28;
    // Widest element the signed-max helper handles; callers sign-extend into it.
    localparam int unsigned SMAX_W     = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4,
        HOLD    = 3'd5
    } pool_state_e;

    // Signed max; on a tie the current (earlier) value is kept.
    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] cur,
        input logic signed [SMAX_W-1:0] cand
    );
        return (cand > cur) ? cand : cur;
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window/output counters with incremental channel/row bases; produces
// source and destination addresses for the pooling FSM.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       MAP_W    = 28,
    parameter int unsigned       MAP_H    = 28,
    parameter int unsigned       CH       = 4,
    parameter logic [ADDR_W-1:0] SRC_BASE = '0,
    parameter logic [ADDR_W-1:0] DST_BASE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step_k,
    input  logic              step_out,
    output logic [1:0]        k,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              last_output
);

    localparam int unsigned OW   = MAP_W / 2;
    localparam int unsigned OH   = MAP_H / 2;
    localparam int unsigned OX_W = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned OY_W = (OH > 1) ? $clog2(OH) : 1;
    localparam int unsigned C_W  = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [ADDR_W-1:0] ROW_OFF  = ADDR_W'(MAP_W);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * MAP_W);
    localparam logic [ADDR_W-1:0] CH_STEP  = ADDR_W'(MAP_W * MAP_H);

    logic [C_W-1:0]    c_q, c_d;
    logic [OY_W-1:0]   oy_q, oy_d;
    logic [OX_W-1:0]   ox_q, ox_d;
    logic [1:0]        k_q, k_d;
    logic [ADDR_W-1:0] chan_base_q, chan_base_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] dst_q, dst_d;

    logic last_ox, last_oy, last_c;

    assign last_ox = (ox_q == OX_W'(OW - 1));
    assign last_oy = (oy_q == OY_W'(OH - 1));
    assign last_c  = (c_q == C_W'(CH - 1));

    // Counter stepping: k within a window, then ox fastest, oy, c; bases follow.
    always_comb begin
        c_d         = c_q;
        oy_d        = oy_q;
        ox_d        = ox_q;
        k_d         = k_q;
        chan_base_d = chan_base_q;
        row_base_d  = row_base_q;
        dst_d       = dst_q;
        if (clear) begin
            c_d         = '0;
            oy_d        = '0;
            ox_d        = '0;
            k_d         = '0;
            chan_base_d = SRC_BASE;
            row_base_d  = SRC_BASE;
            dst_d       = DST_BASE;
        end else if (step_out) begin
            k_d   = '0;
            dst_d = dst_q + ADDR_W'(1);
            if (!last_ox) begin
                ox_d = ox_q + OX_W'(1);
            end else begin
                ox_d = '0;
                if (!last_oy) begin
                    oy_d       = oy_q + OY_W'(1);
                    row_base_d = row_base_q + ROW_STEP;
                end else begin
                    oy_d        = '0;
                    c_d         = last_c ? '0 : c_q + C_W'(1);
                    chan_base_d = chan_base_q + CH_STEP;
                    row_base_d  = chan_base_q + CH_STEP;
                end
            end
        end else if (step_k) begin
            k_d = k_q + 2'd1;
        end
    end

    // Counter and base registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q         <= '0;
            oy_q        <= '0;
            ox_q        <= '0;
            k_q         <= '0;
            chan_base_q <= SRC_BASE;
            row_base_q  <= SRC_BASE;
            dst_q       <= DST_BASE;
        end else begin
            c_q         <= c_d;
            oy_q        <= oy_d;
            ox_q        <= ox_d;
            k_q         <= k_d;
            chan_base_q <= chan_base_d;
            row_base_q  <= row_base_d;
            dst_q       <= dst_d;
        end
    end

    assign k           = k_q;
    assign src_addr    = row_base_q + (k_q[1] ? ROW_OFF : '0)
                       + ADDR_W'({ox_q, 1'b0}) + ADDR_W'(k_q[0]);
    assign dst_addr    = dst_q;
    assign last_output = last_ox && last_oy && last_c;

endmodule

// File: rtl/pool_engine_ctrl.sv
// 2x2 stride-2 max-pool engine behind the pool_en/pool_done handshake.
// Build option: define POOL_RELU_EN to clamp written results at zero.
module pool_engine_ctrl
    import pool_pkg::*;
#(
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       MAP_W    = 28,
    parameter int unsigned       MAP_H    = 28,
    parameter int unsigned       CH       = 4,
    parameter logic [ADDR_W-1:0] SRC_BASE = ADDR_W'(28'h0000000),
    parameter logic [ADDR_W-1:0] DST_BASE = ADDR_W'(28'h0100000)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pool_en,
    output logic                     pool_done,
    output logic                     pool_busy,
    input  logic                     pool_link_read,
    input  logic                     pool_link_write,
    output logic                     mem_rd_req,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic                     mem_rd_valid,
    input  logic signed [DATA_W-1:0] mem_rd_data,
    output logic                     mem_wr_en,
    output logic [ADDR_W-1:0]        mem_wr_addr,
    output logic [DATA_W-1:0]        mem_wr_data
);

    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    pool_state_e state_q, state_d;
    logic signed [DATA_W-1:0] max_q, max_d;

    logic       clear, step_k, step_out, rd_accept;
    logic [1:0] k;
    logic       last_output;

    pool_addr_gen #(
        .ADDR_W  (ADDR_W),
        .MAP_W   (MAP_W),
        .MAP_H   (MAP_H),
        .CH      (CH),
        .SRC_BASE(SRC_BASE),
        .DST_BASE(DST_BASE)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .step_k     (step_k),
        .step_out   (step_out),
        .k          (k),
        .src_addr   (mem_rd_addr),
        .dst_addr   (mem_wr_addr),
        .last_output(last_output)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; dropping pool_en mid-run aborts to IDLE ahead of any other event.
    // IDLE is only re-entered with pool_en low (abort or HOLD exit), so it is always armed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pool_en) state_d = RD_REQ;
            RD_REQ:  if (!pool_en) state_d = IDLE;
                     else if (pool_link_read) state_d = RD_WAIT;
            RD_WAIT: if (!pool_en) state_d = IDLE;
                     else if (mem_rd_valid) state_d = (k == 2'd3) ? WR : RD_REQ;
            WR:      if (!pool_en) state_d = IDLE;
                     else if (pool_link_write) state_d = last_output ? DONE : RD_REQ;
            DONE:    state_d = HOLD;
            HOLD:    if (!pool_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and counter strobes decoded from state, link grants and pool_en.
    always_comb begin
        pool_done  = (state_q == DONE);
        pool_busy  = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR);
        mem_rd_req = (state_q == RD_REQ) && pool_en && pool_link_read;
        mem_wr_en  = (state_q == WR) && pool_en && pool_link_write;
        rd_accept  = (state_q == RD_WAIT) && pool_en && mem_rd_valid;
        clear      = (state_q == IDLE) && pool_en;
        step_k     = rd_accept && (k != 2'd3);
        step_out   = mem_wr_en;
`ifdef POOL_RELU_EN
        mem_wr_data = max_q[DATA_W-1] ? '0 : max_q;
`else
        mem_wr_data = max_q;
`endif
    end

    // Running window maximum; the first element of each window replaces it.
    always_comb begin
        max_d = max_q;
        if (clear) begin
            max_d = MOST_NEG;
        end else if (rd_accept) begin
            max_d = (k == 2'd0) ? mem_rd_data
                  : DATA_W'(smax(SMAX_W'(max_q), SMAX_W'(mem_rd_data)));
        end
    end

    // Max register.
    always_ff @(posedge clk) begin
        if (rst) max_q <= MOST_NEG;
        else     max_q <= max_d;
    end

endmodule

// File: tb/tb_pool_engine_ctrl.sv
// Directed bench for pool_engine_ctrl: 4x4x1 instance (a) and 5x3x2 instance (b).
module tb_pool_engine_ctrl;

    localparam logic [27:0] DST = 28'h0100000;

    typedef struct packed {
        logic [27:0] addr;
        logic [15:0] data;
    } wlog_t;

    typedef struct {
        string              name;
        logic [27:0]        addr;
        logic signed [15:0] data;
    } wr_vec_t;

    typedef struct {
        string              name;
        logic signed [15:0] w0, w1, w2, w3;
        logic signed [15:0] raw;
    } win_vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               en_a, done_a, busy_a, lrd_a, lwr_a, rd_req_a, rd_valid_a, wr_en_a;
    logic [27:0]        rd_addr_a, wr_addr_a;
    logic signed [15:0] rd_data_a;
    logic [15:0]        wr_data_a;
    logic               en_b, done_b, busy_b, lrd_b, lwr_b, rd_req_b, rd_valid_b, wr_en_b;
    logic [27:0]        rd_addr_b, wr_addr_b;
    logic signed [15:0] rd_data_b;
    logic [15:0]        wr_data_b;

    logic signed [15:0] mem_a [64];
    logic signed [15:0] mem_b [64];
    logic [27:0]        rlog_a[$], rlog_b[$];
    wlog_t              wlog_a[$], wlog_b[$];
    int done_cnt_a = 0, done_cnt_b = 0, viol_a = 0, viol_b = 0;

    int n_vec = 0;
    int n_bad = 0;

    pool_engine_ctrl #(.MAP_W(4), .MAP_H(4), .CH(1)) u_dut_a (
        .clk(clk), .rst(rst), .pool_en(en_a), .pool_done(done_a), .pool_busy(busy_a),
        .pool_link_read(lrd_a), .pool_link_write(lwr_a),
        .mem_rd_req(rd_req_a), .mem_rd_addr(rd_addr_a), .mem_rd_valid(rd_valid_a),
        .mem_rd_data(rd_data_a), .mem_wr_en(wr_en_a), .mem_wr_addr(wr_addr_a),
        .mem_wr_data(wr_data_a)
    );

    pool_engine_ctrl #(.MAP_W(5), .MAP_H(3), .CH(2)) u_dut_b (
        .clk(clk), .rst(rst), .pool_en(en_b), .pool_done(done_b), .pool_busy(busy_b),
        .pool_link_read(lrd_b), .pool_link_write(lwr_b),
        .mem_rd_req(rd_req_b), .mem_rd_addr(rd_addr_b), .mem_rd_valid(rd_valid_b),
        .mem_rd_data(rd_data_b), .mem_wr_en(wr_en_b), .mem_wr_addr(wr_addr_b),
        .mem_wr_data(wr_data_b)
    );

    // Memory models with 1-cycle read latency, plus bus monitors.
    always @(posedge clk) begin
        rd_valid_a <= 1'b0;
        rd_valid_b <= 1'b0;
        if (!rst) begin
            if (rd_req_a) begin
                rd_valid_a <= 1'b1;
                rd_data_a  <= mem_a[rd_addr_a[5:0]];
                rlog_a.push_back(rd_addr_a);
            end
            if (rd_req_b) begin
                rd_valid_b <= 1'b1;
                rd_data_b  <= mem_b[rd_addr_b[5:0]];
                rlog_b.push_back(rd_addr_b);
            end
            if (wr_en_a) wlog_a.push_back({wr_addr_a, wr_data_a});
            if (wr_en_b) wlog_b.push_back({wr_addr_b, wr_data_b});
            if (done_a) done_cnt_a <= done_cnt_a + 1;
            if (done_b) done_cnt_b <= done_cnt_b + 1;
            if ((rd_req_a && !lrd_a) || (wr_en_a && !lwr_a) || (done_a && wr_en_a))
                viol_a <= viol_a + 1;
            if ((rd_req_b && !lrd_b) || (wr_en_b && !lwr_b) || (done_b && wr_en_b))
                viol_b <= viol_b + 1;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_wr(input string nm, input bit on_b, input int idx,
                          input logic [27:0] ea, input logic signed [15:0] ed);
        wlog_t e;
        int    n;
        n = on_b ? wlog_b.size() : wlog_a.size();
        if (idx >= n) begin
            chk({nm, "_present"}, n, idx + 1);
            return;
        end
        e = on_b ? wlog_b[idx] : wlog_a[idx];
        chk({nm, "_addr"}, e.addr, ea);
        chk({nm, "_data"}, $signed(e.data), ed);
    endtask

    function automatic logic signed [15:0] post(input logic signed [15:0] r);
`ifdef POOL_RELU_EN
        return (r < 0) ? 16'sd0 : r;
`else
        return r;
`endif
    endfunction

    // One run on instance a: re-arm, start, optional read-link stall and abort.
    // Cycle 0 is the cycle pool_en is first sampled high.
    task automatic run_a(input int s_s, input int s_l, input int abort_at, output int done_cy);
        done_cy = -1;
        en_a    = 1'b0;
        @(negedge clk);
        rlog_a.delete();
        wlog_a.delete();
        en_a  = 1'b1;
        lrd_a = 1'b1;
        lwr_a = 1'b1;
        for (int cy = 1; cy <= 200; cy++) begin
            @(negedge clk);
            if (done_a && done_cy < 0) done_cy = cy;
            if (abort_at > 0 && cy == abort_at) en_a = 1'b0;
            lrd_a = !(cy >= s_s && cy < s_s + s_l);
            if (done_cy > 0 && cy == done_cy + 1) break;
            if (abort_at > 0 && cy == abort_at + 30) break;
        end
    endtask

    task automatic fill_a_ramp();
        for (int i = 0; i < 64; i++) mem_a[i] = 16'(i);
    endtask

    wr_vec_t  v44 [4];
    wr_vec_t  vodd[4];
    win_vec_t wv  [6];

    task automatic set_win(input int i, input string nm, input int a, input int b,
                           input int c, input int d, input int r);
        wv[i].name = nm;
        wv[i].w0 = 16'(a); wv[i].w1 = 16'(b); wv[i].w2 = 16'(c); wv[i].w3 = 16'(d);
        wv[i].raw = 16'(r);
    endtask

    initial begin
        int d, dc, base, bad_rd;

        v44[0] = '{"p44_o0", DST + 28'd0, 16'sd5};
        v44[1] = '{"p44_o1", DST + 28'd1, 16'sd7};
        v44[2] = '{"p44_o2", DST + 28'd2, 16'sd13};
        v44[3] = '{"p44_o3", DST + 28'd3, 16'sd15};
        vodd[0] = '{"odd_c0_o0", DST + 28'd0, 16'sd6};
        vodd[1] = '{"odd_c0_o1", DST + 28'd1, 16'sd8};
        vodd[2] = '{"odd_c1_o0", DST + 28'd2, 16'sd21};
        vodd[3] = '{"odd_c1_o1", DST + 28'd3, 16'sd23};
        set_win(0, "win_all_neg", -3, -1, -8, -2, -1);
        set_win(1, "win_equal", 5, 5, 5, 5, 5);
        set_win(2, "win_most_neg", -32768, -32768, -32768, -32768, -32768);
        set_win(3, "win_extremes", 32767, -32768, 0, 1, 32767);
        set_win(4, "win_mixed", -5, 10, -20, 9, 10);
        set_win(5, "win_zero_first", 0, -1, -1, -1, 0);

        fill_a_ramp();
        for (int i = 0; i < 64; i++) begin
            int idx = i % 15;
            mem_b[i] = ((idx % 5) == 4 || (idx / 5) == 2) ? 16'sd1000 : 16'(i);
        end

        rst = 1'b1;
        en_a = 1'b0; lrd_a = 1'b1; lwr_a = 1'b1;
        en_b = 1'b0; lrd_b = 1'b1; lwr_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_rd_req", rd_req_a, 0);
        chk("rst_wr_en", wr_en_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal 4x4 run.
        dc = done_cnt_a;
        run_a(0, 0, 0, d);
        chk("p44_done_cycle", d, 37);
        chk("p44_busy_after", busy_a, 0);
        chk("p44_done_pulses", done_cnt_a - dc, 1);
        chk("p44_reads", rlog_a.size(), 16);
        chk("p44_writes", wlog_a.size(), 4);
        for (int i = 0; i < 4; i++) chk_wr(v44[i].name, 1'b0, i, v44[i].addr, post(v44[i].data));

        // pool_en held high after done must not restart.
        base = rlog_a.size();
        dc   = done_cnt_a;
        repeat (20) @(negedge clk);
        chk("hold_no_read", rlog_a.size(), base);
        chk("hold_busy", busy_a, 0);
        chk("hold_no_done", done_cnt_a - dc, 0);
        run_a(0, 0, 0, d);
        chk("rearm_done_cycle", d, 37);
        chk("rearm_writes", wlog_a.size(), 4);

        // Read link stalled 10 cycles starting at the k=1 request of output 1.
        run_a(12, 10, 0, d);
        chk("stall_done_cycle", d, 47);
        for (int i = 0; i < 4; i++)
            chk_wr({"stall_", v44[i].name}, 1'b0, i, v44[i].addr, post(v44[i].data));

        // Abort during output 2 in the cycle its first read data returns.
        dc = done_cnt_a;
        run_a(0, 0, 20, d);
        chk("abort_no_done", d, -1);
        chk("abort_done_pulses", done_cnt_a - dc, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_reads", rlog_a.size(), 9);
        chk("abort_writes", wlog_a.size(), 2);
        chk_wr("abort_o0", 1'b0, 0, v44[0].addr, post(v44[0].data));
        chk_wr("abort_o1", 1'b0, 1, v44[1].addr, post(v44[1].data));
        run_a(0, 0, 0, d);
        chk("restart_first_rd", (rlog_a.size() > 0) ? longint'(rlog_a[0]) : -1, 0);
        chk("restart_done_cycle", d, 37);
        chk_wr("restart_o0", 1'b0, 0, v44[0].addr, post(v44[0].data));

        // Window value table applied to output 0 of instance a.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 64; i++) mem_a[i] = 16'sd0;
            mem_a[0] = wv[t].w0; mem_a[1] = wv[t].w1;
            mem_a[4] = wv[t].w2; mem_a[5] = wv[t].w3;
            run_a(0, 0, 0, d);
            chk_wr(wv[t].name, 1'b0, 0, DST, post(wv[t].raw));
        end
        chk("a_bus_violations", viol_a, 0);

        // Odd 5x3 map, two channels, on instance b.
        en_b = 1'b1;
        d    = -1;
        for (int cy = 1; cy <= 200; cy++) begin
            @(negedge clk);
            if (done_b) begin
                d = cy;
                break;
            end
        end
        chk("odd_done_cycle", d, 37);
        chk("odd_reads", rlog_b.size(), 16);
        chk("odd_writes", wlog_b.size(), 4);
        bad_rd = 0;
        foreach (rlog_b[i]) begin
            int idx = int'(rlog_b[i]) % 15;
            if (rlog_b[i] >= 28'd30 || (idx % 5) == 4 || (idx / 5) == 2) bad_rd++;
        end
        chk("odd_ignored_reads", bad_rd, 0);
        for (int i = 0; i < 4; i++) chk_wr(vodd[i].name, 1'b1, i, vodd[i].addr, post(vodd[i].data));
        @(negedge clk);
        chk("odd_done_pulses", done_cnt_b, 1);
        chk("b_bus_violations", viol_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
